fdct_8x8_engine: RTL and testbench

Forward 8x8 2-D DCT engine, the encode-side counterpart of the decompressor's IDCT path. It accepts 64 8-bit pixels of one block in row-major order and computes S = C·P·Cᵀ with one shared multiply-accumulate unit. It streams 64 signed coefficients out in row-major (u, v) order. It feeds the quantizer/compressor test path and uses the same 4096-scaled cosine matrix as the decoder.

---
 rtl/fdct_8x8_engine.sv | 151 +++++++++++++++
 tb/tb_fdct_8x8_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fdct_8x8_engine.sv
`default_nettype none
// ============================================================================
// fdct_8x8_engine : forward 8x8 2-D DCT (S = C*P*C^T), one shared MAC,
//                   row pass then column pass, 4096-scaled cosine table.
// Revision 1.0
// ============================================================================
module fdct_8x8_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [15:0] out_data_o,
  input  logic        out_ready_i,
  output logic        busy_o
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_PASS1 = 2'd1;
  localparam logic [1:0] S_PASS2 = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic [8:0]         cnt_q, cnt_d;
  logic signed [47:0] acc_q, acc_d;

  logic signed [8:0]  p_mem [64];
  logic signed [31:0] t_mem [64];
  logic signed [11:0] s_mem [64];

  // Angle index (2j+1)k mod 32 folded onto the first quadrant of cos().
  function automatic logic signed [12:0] coef(input logic [2:0] k, input logic [2:0] j);
    logic [4:0]         m;
    logic               neg;
    logic signed [12:0] mag;
    m   = {2'd0, k} * {1'b0, j, 1'b1};
    neg = 1'b0;
    if (m > 5'd16) m = 5'd0 - m;
    if (m > 5'd8) begin
      neg = 1'b1;
      m   = 5'd16 - m;
    end
    case (m)
      5'd1:    mag = 13'sd2008;
      5'd2:    mag = 13'sd1892;
      5'd3:    mag = 13'sd1702;
      5'd4:    mag = 13'sd1448;
      5'd5:    mag = 13'sd1137;
      5'd6:    mag = 13'sd783;
      5'd7:    mag = 13'sd399;
      default: mag = 13'sd0;
    endcase
    if (k == 3'd0) begin
      mag = 13'sd1448;
      neg = 1'b0;
    end
    return neg ? -mag : mag;
  endfunction

  logic               w_pass2;
  logic               w_in_fire;
  logic [2:0]         w_ck;
  logic signed [12:0] w_coef;
  logic signed [8:0]  w_pv;
  logic signed [31:0] w_tv;
  logic signed [47:0] w_mul_a, w_mul_b, w_prod, w_acc_sum, w_sh2;
  logic signed [31:0] w_t_wr;
  logic signed [11:0] w_sat, w_sv;

  assign in_ready_o  = (state_q == S_LOAD);
  assign out_valid_o = (state_q == S_OUT);
  assign busy_o      = (state_q != S_LOAD);
  assign w_in_fire   = in_valid_i && in_ready_o;
  assign w_pass2     = (state_q == S_PASS2);

  // PASS1 counter = {r,k,j}; PASS2 counter = {u,v,r}; innermost term in [2:0].
  assign w_ck   = w_pass2 ? cnt_q[8:6] : cnt_q[5:3];
  assign w_coef = coef(w_ck, cnt_q[2:0]);
  assign w_pv   = p_mem[{cnt_q[8:6], cnt_q[2:0]}];
  assign w_tv   = t_mem[{cnt_q[2:0], cnt_q[5:3]}];

  assign w_mul_a   = w_pass2 ? {{16{w_tv[31]}}, w_tv} : {{39{w_pv[8]}}, w_pv};
  assign w_mul_b   = {{35{w_coef[12]}}, w_coef};
  assign w_prod    = w_mul_a * w_mul_b;
  assign w_acc_sum = ((cnt_q[2:0] == 3'd0) ? 48'sd0 : acc_q) + w_prod;
  assign w_t_wr    = 32'(w_acc_sum >>> 8);
  assign w_sh2     = w_acc_sum >>> 16;

  always_comb begin
    w_sat = w_sh2[11:0];
    if (w_sh2 > 48'sd2047)       w_sat = 12'sd2047;
    else if (w_sh2 < -48'sd2048) w_sat = -12'sd2048;
  end

  assign w_sv       = s_mem[idx_q];
  assign out_data_o = out_valid_o ? {{4{w_sv[11]}}, w_sv} : 16'd0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      S_LOAD: begin
        if (w_in_fire) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd63) state_d = S_PASS1;
        end
      end
      S_PASS1, S_PASS2: begin
        acc_d = w_acc_sum;
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == 9'd511) state_d = w_pass2 ? S_OUT : S_PASS2;
      end
      S_OUT: begin
        if (out_ready_i) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd63) state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      idx_q   <= 6'd0;
      cnt_q   <= 9'd0;
      acc_q   <= 48'sd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire)
      p_mem[idx_q] <= $signed({1'b0, in_data_i}) - 9'sd128;
    if (state_q == S_PASS1 && cnt_q[2:0] == 3'd7)
      t_mem[{cnt_q[8:6], cnt_q[5:3]}] <= w_t_wr;
    if (w_pass2 && cnt_q[2:0] == 3'd7)
      s_mem[{cnt_q[8:6], cnt_q[5:3]}] <= w_sat;
  end

endmodule
`default_nettype wire

// File: tb/tb_fdct_8x8_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_fdct_8x8_engine : directed blocks with constant expectations and a
//                      floor-shift reference model; stall, timing and reset.
// Revision 1.0
// ============================================================================
module tb_fdct_8x8_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic        busy;

  fdct_8x8_engine u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int ct [64] = '{
    1448,  1448,  1448,  1448,  1448,  1448,  1448,  1448,
    2008,  1702,  1137,   399,  -399, -1137, -1702, -2008,
    1892,   783,  -783, -1892, -1892,  -783,   783,  1892,
    1702,  -399, -2008, -1137,  1137,  2008,   399, -1702,
    1448, -1448, -1448,  1448,  1448, -1448, -1448,  1448,
    1137, -2008,   399,  1702, -1702,  -399,  2008, -1137,
     783, -1892,  1892,  -783,  -783,  1892, -1892,   783,
     399, -1137,  1702, -2008,  2008, -1702,  1137,  -399
  };

  int pix   [64];
  int exp_s [64];
  int res   [64];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model();
    longint t [64];
    longint acc;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) begin
        acc = 0;
        for (int j = 0; j < 8; j++) acc += longint'((pix[r*8+j] - 128) * ct[k*8+j]);
        t[r*8+k] = acc >>> 8;
      end
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) begin
        acc = 0;
        for (int r = 0; r < 8; r++) acc += longint'(ct[u*8+r]) * t[r*8+v];
        acc = acc >>> 16;
        if (acc > 2047) acc = 2047;
        if (acc < -2048) acc = -2048;
        exp_s[u*8+v] = int'(acc);
      end
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        case (mode)
          0: pix[r*8+c] = 128;
          1: pix[r*8+c] = 255;
          2: pix[r*8+c] = 0;
          3: pix[r*8+c] = 128 + 16*c;
          4: pix[r*8+c] = (r*37 + c*53 + 11) % 256;
          default: pix[r*8+c] = ((r + c) % 2 == 1) ? 255 : 0;
        endcase
  endtask

  // Ends just after the edge that accepts the 64th sample.
  task automatic send_block(input bit hold_valid);
    int i = 0;
    int guard = 0;
    logic [7:0] d;
    while (i < 64 && guard < 200) begin
      @(negedge clk);
      d        = pix[i][7:0];
      in_valid = 1'b1;
      in_data  = d;
      if (in_ready) i++;
      guard++;
    end
    if (i < 64) check("send_timeout", i, 64);
    @(posedge clk);
    #1;
    in_data = 8'hA5;
    if (!hold_valid) in_valid = 1'b0;
    check("busy_rise", busy, 1);
  endtask

  task automatic wait_out(input bit hold_valid);
    int lat = 0;
    bit busy_low = 1'b0;
    bit ready_seen = 1'b0;
    @(negedge clk);
    check("valid_early", out_valid, 0);
    while (!out_valid && lat < 1200) begin
      if (!busy) busy_low = 1'b1;
      if (in_ready) ready_seen = 1'b1;
      if (hold_valid) in_data = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 1024);
    check("busy_drop_in_pass", busy_low, 0);
    check("in_ready_in_pass", ready_seen, 0);
  endtask

  task automatic collect(input bit rnd, input int stop_at);
    int got = 0;
    int cyc = 0;
    bit have_prev = 1'b0;
    int prev = 0;
    bit rdy;
    while (got < stop_at && cyc < 1000) begin
      check("out_valid_hold", out_valid, 1);
      check("busy_out", busy, 1);
      if (rnd) check("in_ready_out", in_ready, 0);
      if (have_prev) check("stall_hold", int'($signed(out_data)), prev);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (rdy) begin
        res[got]  = int'($signed(out_data));
        got++;
        have_prev = 1'b0;
      end else begin
        prev      = int'($signed(out_data));
        have_prev = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (got < stop_at) check("collect_timeout", got, stop_at);
    if (!rnd && stop_at == 64) check("out_cycles", cyc, 64);
  endtask

  task automatic run_block(input string tag, input bit rnd);
    model();
    send_block(rnd);
    wait_out(rnd);
    collect(rnd, 64);
    check({tag, "_in_ready_back"}, in_ready, 1);
    check({tag, "_no_extra"}, out_valid, 0);
    check({tag, "_busy_back"}, busy, 0);
    for (int i = 0; i < 64; i++)
      check($sformatf("%s_S%0d", tag, i), res[i], exp_s[i]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;

    fill(0);
    run_block("flat128", 1'b0);
    for (int i = 0; i < 64; i++) check($sformatf("flat128_zero%0d", i), res[i], 0);

    fill(1);
    run_block("flat255", 1'b0);
    check("flat255_dc", res[0], 1015);
    check("flat255_ac1", res[1], 0);
    check("flat255_ac63", res[63], 0);

    fill(2);
    run_block("flat0", 1'b0);
    check("flat0_dc", res[0], -1024);
    check("flat0_ac8", res[8], 0);

    fill(3);
    run_block("hramp", 1'b0);
    for (int i = 8; i < 64; i++) check($sformatf("hramp_rowzero%0d", i), res[i], 0);

    fill(4);
    run_block("stall", 1'b1);

    fill(5);
    send_block(1'b0);
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_pass1");
    @(negedge clk);
    rst_n = 1'b1;
    fill(3);
    run_block("after_rst1", 1'b0);

    fill(4);
    send_block(1'b0);
    wait_out(1'b0);
    collect(1'b0, 10);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("rst_out");
    @(negedge clk);
    rst_n = 1'b1;
    fill(5);
    run_block("after_rst2", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
